// File: rtl/miriscv_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// miriscv_mem_arbiter_if
// Bundle of every handshake/bus signal around the instruction/data memory
// arbiter. Signal suffixes are written from the arbiter's point of view
// (_i = into the arbiter, _o = out of the arbiter).
//   instr_* : core instruction port (req/addr in, gnt/rvalid/rdata out)
//   data_*  : core data port (req/we/be/addr/wdata in, gnt/rvalid/rdata out)
//   mem_*   : single-port memory side (req/we/be/addr/wdata out,
//             gnt/rvalid/rdata in)
// Modports:
//   slave  : the arbiter itself
//   master : the environment (cores plus memory) that faces the arbiter
// ---------------------------------------------------------------------------
interface miriscv_mem_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// miriscv_mem_arbiter
// Merges the miriscv instruction and data memory ports onto one single-port
// memory using req/gnt handshakes. The source of every granted request is
// kept in an in-order tracking FIFO so each memory response is steered back
// to the port that issued it.
// Parameters:
//   OUTSTANDING : tracking FIFO depth (power of two, >= 2)
//   DATA_PRIO   : 0 = round-robin on conflict, 1 = data port always wins
// Ports:
//   clk_i   : clock
//   arstn_i : asynchronous active-low reset
//   bus     : instruction, data and memory handshake signals (slave view)
//   err_o   : sticky flag, set by a memory response with nothing outstanding
// ---------------------------------------------------------------------------
module miriscv_mem_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter bit DATA_PRIO   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  miriscv_mem_arbiter_if.slave  bus,
  output logic                  err_o
);

  localparam int   PTR_W = $clog2(OUTSTANDING);
  localparam int   CNT_W = PTR_W + 1;
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  logic             r_lock;
  logic             r_lock_src;
  logic             r_last_winner;
  logic             r_err;
  logic             r_fifo [OUTSTANDING];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_sel;
  logic             w_full;
  logic             w_empty;
  logic             w_mem_req;
  logic             w_grant;
  logic             w_pop;
  logic             w_head;

  assign w_full  = (r_count == CNT_W'(OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // A stalled request keeps its source so the memory never sees the payload
  // switch between ports before it is accepted.
  always_comb begin
    w_sel = ~r_last_winner;
    if (r_lock) begin
      w_sel = r_lock_src;
    end else if (bus.instr_req_i && !bus.data_req_i) begin
      w_sel = SRC_I;
    end else if (bus.data_req_i && !bus.instr_req_i) begin
      w_sel = SRC_D;
    end else if (bus.instr_req_i && bus.data_req_i) begin
      w_sel = DATA_PRIO ? SRC_D : ~r_last_winner;
    end
  end

  // Gating with arstn_i keeps every request/grant low while reset is held,
  // independent of what the requesters drive.
  assign w_mem_req = arstn_i & (bus.instr_req_i | bus.data_req_i) & ~w_full;
  assign w_grant   = w_mem_req & bus.mem_gnt_i;
  assign w_pop     = bus.mem_rvalid_i & ~w_empty;

  assign bus.mem_req_o   = w_mem_req;
  assign bus.mem_we_o    = (w_sel == SRC_D) ? bus.data_we_i    : 1'b0;
  assign bus.mem_be_o    = (w_sel == SRC_D) ? bus.data_be_i    : 4'hF;
  assign bus.mem_addr_o  = (w_sel == SRC_D) ? bus.data_addr_i  : bus.instr_addr_i;
  assign bus.mem_wdata_o = (w_sel == SRC_D) ? bus.data_wdata_i : 32'h0;

  assign bus.instr_gnt_o = w_grant & (w_sel == SRC_I);
  assign bus.data_gnt_o  = w_grant & (w_sel == SRC_D);

  // A response with an empty FIFO has no owner and is dropped here.
  assign bus.instr_rvalid_o = w_pop & (w_head == SRC_I);
  assign bus.data_rvalid_o  = w_pop & (w_head == SRC_D);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;

  assign err_o = r_err;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_lock        <= 1'b0;
      r_lock_src    <= SRC_I;
      r_last_winner <= SRC_D;
      r_err         <= 1'b0;
    end else begin
      if (w_grant) begin
        r_lock        <= 1'b0;
        r_last_winner <= w_sel;
      end else if (w_mem_req) begin
        r_lock     <= 1'b1;
        r_lock_src <= w_sel;
      end
      if (bus.mem_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // Pushes only happen with mem_req_o high, which already excludes a full
  // FIFO, so a same-cycle pop never frees a slot early.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_grant) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_fifo[r_wptr] <= w_sel;
    end
  end

endmodule

// File: doc/miriscv_mem_arbiter.md
Name: miriscv_mem_arbiter

Overview:
- Sits between the miriscv core's instruction and data memory interfaces and a single-port memory.
- Arbitrates the two requesters onto one memory port using a req/gnt handshake.
- Records the source of every granted request in an in-order tracking FIFO and routes each memory response back to that source.
- Lets the bench and SoC use one unified memory array in place of separate instruction and data paths.

Parameters:
- OUTSTANDING, 4: depth of the source-tracking FIFO, i.e. maximum granted-but-unanswered requests; power of two, ≥2.
- DATA_PRIO, 0: 0 = round-robin arbitration; 1 = data port wins every conflict.

Ports:
- clk_i  input  1  clock
- arstn_i  input  1  asynchronous active-low reset
- instr_req_i  input  1  instruction request
- instr_addr_i  input  32  instruction byte address
- instr_gnt_o  output  1  instruction request accepted this cycle
- instr_rvalid_o  output  1  instruction response valid
- instr_rdata_o  output  32  instruction response data
- data_req_i  input  1  data request
- data_we_i  input  1  1 = write
- data_be_i  input  4  byte enables
- data_addr_i  input  32  data byte address
- data_wdata_i  input  32  write data
- data_gnt_o  output  1  data request accepted this cycle
- data_rvalid_o  output  1  data response valid (reads and writes)
- data_rdata_o  output  32  data response data
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write
- mem_be_o  output  4  memory byte enables
- mem_addr_o  output  32  memory byte address
- mem_wdata_o  output  32  memory write data
- mem_gnt_i  input  1  memory accepted request
- mem_rvalid_i  input  1  memory response valid, in request order
- mem_rdata_i  input  32  memory response data
- err_o  output  1  sticky protocol error

Behaviour:
Reset (arstn_i low, asynchronous):
- FIFO empty, lock cleared, last_winner = DATA (so instr wins the first round-robin conflict), err_o = 0.
- All *_gnt_o, *_rvalid_o and mem_req_o are 0 while in reset.

Selection (combinational):
- If lock is set, sel = locked source.
- Otherwise:
  - only one req → that source;
  - both → DATA when DATA_PRIO = 1, else the source that is not last_winner.

Memory port:
- mem_req_o = (instr_req_i | data_req_i) & !fifo_full.
- mem_we/be/addr/wdata are muxed from sel. For an instr selection: we = 0, be = 4'hF, wdata = 0.

Grant:
- <sel>_gnt_o = mem_req_o & mem_gnt_i; the other port's gnt = 0. Zero-cycle pass-through from mem_gnt_i.

Lock:
- Set to sel when mem_req_o & !mem_gnt_i, so the address/data never switch source while stalled.
- Cleared on the granting cycle.

last_winner:
- Updated to sel on every grant.

Tracking FIFO:
- Push sel on a grant; pop on mem_rvalid_i.
- Full check uses the registered count only. A push is blocked when full even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full leaves the count unchanged.
- Pointers wrap modulo OUTSTANDING.

Response routing (combinational, same cycle as mem_rvalid_i):
- instr_rvalid_o = mem_rvalid_i & fifo_head == INSTR; data_rvalid_o likewise for DATA.
- Both rdata outputs = mem_rdata_i unconditionally.

Protocol error:
- mem_rvalid_i while the FIFO is empty is dropped: no rvalid asserted, err_o set.
- err_o stays set until reset.

Requester contract:
- A requester must hold req and its payload stable until gnt. The arbiter does not check this.

Test Plan:
- Reset release, instr_req_i = 1 @0x0 only, memory gnt = 1 and rvalid one cycle later with 0x00000013 → instr_gnt_o = 1 in cycle 0; instr_rvalid_o = 1, instr_rdata_o = 0x00000013 in cycle 1; data_rvalid_o stays 0.
- DATA_PRIO = 0, both requests held continuously, mem_gnt_i = 1 → grants alternate I, D, I, D starting with instr; each rvalid routed to the matching port in order.
- Data write be = 4'b0101, addr 0x40, wdata 0xAABBCCDD, mem_gnt_i = 0 for 3 cycles then 1, instr_req raised during the stall → mem outputs hold the data payload throughout; data_gnt_o pulses on cycle 3; instr is granted next.
- mem_rvalid_i held 0, OUTSTANDING = 4, mem_gnt_i = 1 with instr_req continuous → exactly 4 grants, then mem_req_o = 0. A single mem_rvalid_i re-enables mem_req_o in the following cycle, not the same cycle.
- mem_rvalid_i pulsed after reset with no request → no rvalid on either port; err_o = 1 and stays 1 until arstn_i is asserted mid-test, which clears err_o and the FIFO.
- DATA_PRIO = 1, both requests held for 5 cycles, then data_req dropped → 5 data grants, 0 instr grants, then instr granted on the next cycle.
